riscvvec_mem_arbiter: RTL and testbench

Two-requester, single-port memory arbiter for the riscvvec core. It shares one memory request/response port between the instruction port (port 0) and the data port (port 1). This lets the core run against a single-port test memory or cache instead of a dual-port one. Requests are granted round-robin, and a tag FIFO of outstanding grants routes the in-order memory responses back to the correct requester.

---
 rtl/riscvvec_mem_arbiter.sv | 102 ++++++++++
 tb/tb_riscvvec_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscvvec_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction (0) and
// data (1) ports; a tag FIFO of granted port IDs steers in-order responses back.
module riscvvec_mem_arbiter #(
  parameter int p_req_msg_sz      = 67,
  parameter int p_resp_msg_sz     = 35,
  parameter int p_max_outstanding = 4,
  parameter int ptr_w             = $clog2(p_max_outstanding),
  parameter int cnt_w             = ptr_w + 1
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req0_val,
  output logic                     req0_rdy,
  input  logic [p_req_msg_sz-1:0]  req0_msg,
  output logic                     resp0_val,
  input  logic                     resp0_rdy,
  output logic [p_resp_msg_sz-1:0] resp0_msg,

  input  logic                     req1_val,
  output logic                     req1_rdy,
  input  logic [p_req_msg_sz-1:0]  req1_msg,
  output logic                     resp1_val,
  input  logic                     resp1_rdy,
  output logic [p_resp_msg_sz-1:0] resp1_msg,

  output logic                     memreq_val,
  input  logic                     memreq_rdy,
  output logic [p_req_msg_sz-1:0]  memreq_msg,
  input  logic                     memresp_val,
  output logic                     memresp_rdy,
  input  logic [p_resp_msg_sz-1:0] memresp_msg,

  output logic [31:0]              num_conflicts,
  output logic                     dbg_prio,
  output logic [cnt_w-1:0]         dbg_count
);

  // Handshake rule on every port: a transfer happens on a rising clk edge
  // exactly when val and rdy are both high; val never waits on rdy.

  logic             prio;
  logic             tags [p_max_outstanding];
  logic [ptr_w-1:0] head_ptr;
  logic [ptr_w-1:0] tail_ptr;
  logic [cnt_w-1:0] count;

  logic sel;
  logic full;
  logic empty;
  logic head_port;
  logic push;
  logic pop;
  logic conflict;

  assign full      = (count == cnt_w'(p_max_outstanding));
  assign empty     = (count == '0);
  assign conflict  = req0_val & req1_val;
  assign sel       = conflict ? prio : req1_val;
  assign head_port = tags[head_ptr];

  // Outputs are forced low while reset is high so nothing fires during reset.
  assign memreq_val = ~reset & (req0_val | req1_val) & ~full;
  assign memreq_msg = sel ? req1_msg : req0_msg;
  assign req0_rdy   = ~reset & memreq_rdy & ~full & ~sel;
  assign req1_rdy   = ~reset & memreq_rdy & ~full &  sel;
  assign push       = memreq_val & memreq_rdy;

  assign resp0_val   = ~reset & memresp_val & ~empty & ~head_port;
  assign resp1_val   = ~reset & memresp_val & ~empty &  head_port;
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign memresp_rdy = ~reset & ~empty & (head_port ? resp1_rdy : resp0_rdy);
  assign pop         = memresp_val & memresp_rdy;

  assign dbg_prio  = prio;
  assign dbg_count = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio          <= 1'b0;
      head_ptr      <= '0;
      tail_ptr      <= '0;
      count         <= '0;
      num_conflicts <= 32'd0;
    end else begin
      if (push) begin
        tags[tail_ptr] <= sel;
        tail_ptr       <= tail_ptr + ptr_w'(1);
        prio           <= ~sel;
        if (conflict) num_conflicts <= num_conflicts + 32'd1;
      end
      if (pop) head_ptr <= head_ptr + ptr_w'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_riscvvec_mem_arbiter.sv
// Directed bench for riscvvec_mem_arbiter: grant order, outstanding limit,
// response routing, head-of-line blocking and reset behaviour.
module tb_riscvvec_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic        req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic [66:0] req0_msg, req1_msg, memreq_msg;
  logic [34:0] resp0_msg, resp1_msg, memresp_msg;
  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [31:0] num_conflicts;
  logic        dbg_prio;
  logic [2:0]  dbg_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  riscvvec_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .num_conflicts(num_conflicts), .dbg_prio(dbg_prio), .dbg_count(dbg_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
    resp0_rdy = 1; resp1_rdy = 1;
    memreq_rdy = 1; memresp_val = 0; memresp_msg = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  initial begin
    int acc;
    logic [63:0] e;

    // ---- reset: outputs held low even with all inputs active ----
    clear_inputs();
    reset = 1; req0_val = 1; req1_val = 1; memresp_val = 1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_memreq_val", 64'(memreq_val), 0);
    check("rst_req0_rdy", 64'(req0_rdy), 0);
    check("rst_req1_rdy", 64'(req1_rdy), 0);
    check("rst_resp0_val", 64'(resp0_val), 0);
    check("rst_resp1_val", 64'(resp1_val), 0);
    check("rst_memresp_rdy", 64'(memresp_rdy), 0);
    check("rst_conflicts", 64'(num_conflicts), 0);
    check("rst_count", 64'(dbg_count), 0);
    check("rst_prio", 64'(dbg_prio), 0);
    clear_inputs();
    reset = 0;
    cyc();

    // ---- port 0 only, memory answers the cycle after each grant ----
    for (int k = 0; k <= 8; k++) begin
      req0_val = (k < 8);
      req0_msg = 67'(32'h1000 + 4 * k);
      memresp_val = (exp_q.size() != 0);
      memresp_msg = (exp_q.size() != 0) ? 35'(exp_q[0]) : '0;
      #1;
      if (k < 8) begin
        check("p0_rdy", 64'(req0_rdy), 1);
        check("p0_memreq", 64'(memreq_msg), 64'(32'h1000 + 4 * k));
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("p0_resp_val", 64'(resp0_val), 1);
        check("p0_resp_msg", 64'(resp0_msg), e);
      end
      check("p0_resp1_val", 64'(resp1_val), 0);
      if (k < 8) exp_q.push_back(64'(32'h1000 + 4 * k));
      cyc();
    end
    clear_inputs();
    #1;
    check("p0_conflicts", 64'(num_conflicts), 0);
    check("p0_count", 64'(dbg_count), 0);

    // ---- both ports valid for 10 grants: alternate starting at port 0 ----
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      req0_val = (k < 10); req1_val = (k < 10);
      req0_msg = 67'(16'h2000 + k); req1_msg = 67'(16'h3000 + k);
      memresp_val = (k >= 1);
      memresp_msg = 35'(k);
      #1;
      if (k < 10) begin
        check("rr_memreq", 64'(memreq_msg), (k % 2 == 0) ? 64'(16'h2000 + k) : 64'(16'h3000 + k));
        check("rr_req0_rdy", 64'(req0_rdy), (k % 2 == 0) ? 1 : 0);
        check("rr_req1_rdy", 64'(req1_rdy), (k % 2 == 1) ? 1 : 0);
      end
      if (k >= 1) begin
        check("rr_resp0_val", 64'(resp0_val), ((k - 1) % 2 == 0) ? 1 : 0);
        check("rr_resp1_val", 64'(resp1_val), ((k - 1) % 2 == 1) ? 1 : 0);
      end
      cyc();
    end
    clear_inputs();
    #1;
    check("rr_conflicts", 64'(num_conflicts), 10);
    check("rr_count", 64'(dbg_count), 0);

    // ---- outstanding limit: memory silent for 20 cycles ----
    do_reset();
    acc = 0;
    req1_val = 1;
    for (int k = 0; k < 20; k++) begin
      req1_msg = 67'(16'h4000 + acc);
      #1;
      check("lim_rdy", 64'(req1_rdy), (acc < 4) ? 1 : 0);
      if (req1_rdy) acc++;
      cyc();
    end
    check("lim_accepted", 64'(acc), 4);
    check("lim_memreq_val", 64'(memreq_val), 0);
    memresp_val = 1;
    #1;
    check("lim_pop_rdy", 64'(memresp_rdy), 1);
    check("lim_pop_val", 64'(resp1_val), 1);
    check("lim_same_cycle_rdy", 64'(req1_rdy), 0);
    cyc();
    memresp_val = 0;
    #1;
    check("lim_next_cycle_rdy", 64'(req1_rdy), 1);
    cyc();
    check("lim_full_again", 64'(req1_rdy), 0);
    check("lim_count", 64'(dbg_count), 4);

    // ---- interleaved routing: grants 0,1,1,0 then data A,B,C,D ----
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req0_val = (k == 0 || k == 3);
      req1_val = (k == 1 || k == 2);
      req0_msg = 67'(k); req1_msg = 67'(k);
      #1;
      check("ilv_memreq_val", 64'(memreq_val), 1);
      check("ilv_grant_msg", 64'(memreq_msg), 64'(k));
      cyc();
    end
    req0_val = 0; req1_val = 0;
    for (int k = 0; k < 4; k++) begin
      memresp_val = 1;
      memresp_msg = 35'(4'hA + k);
      #1;
      check("ilv_resp0_val", 64'(resp0_val), (k == 0 || k == 3) ? 1 : 0);
      check("ilv_resp1_val", 64'(resp1_val), (k == 1 || k == 2) ? 1 : 0);
      check("ilv_resp_msg", (k == 0 || k == 3) ? 64'(resp0_msg) : 64'(resp1_msg), 64'(4'hA + k));
      cyc();
    end
    memresp_val = 0;
    #1;
    check("ilv_count", 64'(dbg_count), 0);

    // ---- head-of-line blocking: port-0 response stuck at the head ----
    do_reset();
    req0_val = 1; cyc();
    req0_val = 0; req1_val = 1; cyc();
    req1_val = 0;
    resp0_rdy = 0; memresp_val = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("hol_memresp_rdy", 64'(memresp_rdy), 0);
      check("hol_resp1_val", 64'(resp1_val), 0);
      check("hol_resp0_val", 64'(resp0_val), 1);
      cyc();
    end
    resp0_rdy = 1;
    #1;
    check("hol_release_rdy", 64'(memresp_rdy), 1);
    cyc();
    check("hol_second_resp1", 64'(resp1_val), 1);
    check("hol_second_resp0", 64'(resp0_val), 0);
    cyc();
    memresp_val = 0;
    #1;
    check("hol_count", 64'(dbg_count), 0);

    // ---- reset with 3 outstanding and prio = 1 ----
    do_reset();
    req1_val = 1; cyc();
    cyc();
    req0_val = 1; cyc();
    check("mid_prio_before", 64'(dbg_prio), 1);
    check("mid_count_before", 64'(dbg_count), 3);
    check("mid_conflicts_before", 64'(num_conflicts), 1);
    reset = 1; memresp_val = 1;
    #1;
    check("mid_rst_memresp_rdy", 64'(memresp_rdy), 0);
    check("mid_rst_req1_rdy", 64'(req1_rdy), 0);
    cyc();
    reset = 0; req0_val = 0; req1_val = 0; memreq_rdy = 0;
    #1;
    check("mid_count", 64'(dbg_count), 0);
    check("mid_prio", 64'(dbg_prio), 0);
    check("mid_conflicts", 64'(num_conflicts), 0);
    check("mid_memresp_rdy", 64'(memresp_rdy), 0);
    check("mid_vals", 64'({memreq_val, resp0_val, resp1_val}), 0);
    check("mid_rdys", 64'({req0_rdy, req1_rdy}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
